// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-client SDRAM port arbiter:
// state encoding, default burst/timeout sizes and client indices.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    localparam int DEFAULT_BURST_LEN = 8;
    localparam int DEFAULT_TIMEOUT   = 1023;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    // One extra bit so the counter can hold BURST_LEN itself.
    function automatic int burstCntWidth(input int len);
        return $clog2(len) + 1;
    endfunction

endpackage

// File: rtl/sdram_arb_wdog.sv
// Stall watchdog for the arbiter: counts cycles without progress while
// enabled, cleared whenever progress is seen or the burst is not active.
// expire_o flags the cycle whose edge would make the count reach LIMIT.
module sdram_arb_wdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] stallCnt_q;
    logic [W-1:0] stallCnt_d;

    // Clear has priority; the count saturates at LIMIT so it can never wrap.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (clr_i) begin
            stallCnt_d = '0;
        end else if (en_i && (stallCnt_q != W'(LIMIT))) begin
            stallCnt_d = stallCnt_q + W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign expire_o = en_i && !clr_i && (stallCnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/sdram_port_arb.sv
// Two-client round-robin arbiter in front of the SDRAM burst controller.
// Grants one client per burst, latches its address and direction, issues
// the controller strobe, routes word strobes and data, counts the burst
// and aborts through a watchdog if the controller stalls mid-burst.
module sdram_port_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADR_W     = 25,
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req,
    input  logic              c1_req,
    input  logic              c0_we,
    input  logic              c1_we,
    input  logic [ADR_W-1:0]  c0_adr,
    input  logic [ADR_W-1:0]  c1_adr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_gnt,
    output logic              c1_gnt,
    output logic              c0_valid,
    output logic              c1_valid,
    output logic              c0_done,
    output logic              c1_done,
    output logic [DATA_W-1:0] c_rdata,
    output logic              err,
    output logic              busy,
    input  logic              ready,
    output logic              wr_req,
    output logic              rd_req,
    input  logic              wr_valid,
    input  logic              rd_valid,
    output logic [ADR_W-1:0]  adr_sdram,
    output logic [DATA_W-1:0] data_to_sdram,
    input  logic [DATA_W-1:0] data_from_sdram
);

    localparam int               CNT_W     = burstCntWidth(BURST_LEN);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    arb_state_t        state_q, state_d;
    logic              sel_q, sel_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [ADR_W-1:0]  adr_q, adr_d;
    logic [CNT_W-1:0]  burstCnt_q, burstCnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              err_q, err_d;

    logic              active;
    logic              matchValid;
    logic              wordValid;
    logic              wdExpire;
    logic              abortBurst;
    logic              reqAny;
    logic              winner;
    logic [CNT_W-1:0]  cntInc;

    assign active     = (state_q == ST_ISSUE) || (state_q == ST_XFER);
    assign matchValid = we_q ? wr_valid : rd_valid;
    assign wordValid  = active && matchValid;
    assign abortBurst = active && wdExpire;
    assign cntInc     = burstCnt_q + CNT_W'(1);
    assign reqAny     = c0_req || c1_req;

    // Round-robin pick: on a tie the client that was not served last wins.
    always_comb begin
        winner = CLIENT0;
        if (c0_req && c1_req) begin
            winner = ~last_q;
        end else if (c1_req) begin
            winner = CLIENT1;
        end
    end

    // Watchdog only runs while a burst is waiting on the controller; any
    // matching word or leaving the active states restarts it.
    sdram_arb_wdog #(
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (!active || matchValid),
        .en_i     (active),
        .expire_o (wdExpire)
    );

    // Burst sequencing: grant, issue, count words, finish or abort.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        last_d     = last_q;
        adr_d      = adr_q;
        burstCnt_d = burstCnt_q;
        gnt_d      = gnt_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqAny) begin
                    state_d = ST_GRANT;
                    sel_d   = winner;
                    if (winner == CLIENT1) begin
                        we_d  = c1_we;
                        adr_d = c1_adr;
                        gnt_d = 2'b10;
                    end else begin
                        we_d  = c0_we;
                        adr_d = c0_adr;
                        gnt_d = 2'b01;
                    end
                end
            end

            ST_GRANT: begin
                state_d    = ST_ISSUE;
                burstCnt_d = '0;
            end

            ST_ISSUE, ST_XFER: begin
                if (abortBurst) begin
                    state_d    = ST_IDLE;
                    gnt_d      = 2'b00;
                    err_d      = 1'b1;
                    last_d     = sel_q;
                    burstCnt_d = '0;
                end else if (matchValid) begin
                    burstCnt_d = cntInc;
                    if (cntInc == BURST_CNT) begin
                        state_d = ST_DONE;
                        gnt_d   = 2'b00;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                last_d     = sel_q;
                burstCnt_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // State and datapath registers; last starts at 1 so c0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= CLIENT0;
            we_q       <= 1'b0;
            last_q     <= CLIENT1;
            adr_q      <= '0;
            burstCnt_q <= '0;
            gnt_q      <= 2'b00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            last_q     <= last_d;
            adr_q      <= adr_d;
            burstCnt_q <= burstCnt_d;
            gnt_q      <= gnt_d;
            err_q      <= err_d;
        end
    end

    // Client-facing handshakes follow the selected client.
    always_comb begin
        c0_valid = wordValid && (sel_q == CLIENT0);
        c1_valid = wordValid && (sel_q == CLIENT1);
        c0_done  = (state_q == ST_DONE) && (sel_q == CLIENT0);
        c1_done  = (state_q == ST_DONE) && (sel_q == CLIENT1);
    end

    // Controller strobes are only offered while the controller is ready;
    // moving to XFER on the first word drops the strobe.
    always_comb begin
        wr_req = (state_q == ST_ISSUE) && ready && we_q;
        rd_req = (state_q == ST_ISSUE) && ready && !we_q;
    end

    // Write data follows the selected client; held at zero when idle.
    always_comb begin
        data_to_sdram = '0;
        if (state_q != ST_IDLE) begin
            data_to_sdram = (sel_q == CLIENT1) ? c1_wdata : c0_wdata;
        end
    end

    assign c0_gnt    = gnt_q[0];
    assign c1_gnt    = gnt_q[1];
    assign c_rdata   = data_from_sdram;
    assign adr_sdram = adr_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_port_arb.sv
// Directed bench for sdram_port_arb: a cycle table for one write burst,
// then hand-written sequences for read routing, ready stalls, watchdog
// abort, round-robin fairness and asynchronous reset mid-burst.
module tb_sdram_port_arb;

    localparam logic [24:0] ADR0 = 25'h0000100;
    localparam logic [24:0] ADR1 = 25'h0ABCDE;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_req, c1_req, c0_we, c1_we;
    logic [24:0] c0_adr, c1_adr;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c1_gnt, c0_valid, c1_valid, c0_done, c1_done;
    logic [15:0] c_rdata;
    logic        err, busy, ready, wr_req, rd_req, wr_valid, rd_valid;
    logic [24:0] adr_sdram;
    logic [15:0] data_to_sdram, data_from_sdram;

    int vecCount  = 0;
    int missCount = 0;

    // Stimulus bits {c0_req,c1_req,c0_we,c1_we,ready,wr_valid,rd_valid};
    // expected bits {c0_gnt,c1_gnt,c0_valid,c1_valid,c0_done,c1_done,
    // wr_req,rd_req,err,busy}.
    typedef struct {
        logic [6:0]  stim;
        logic [9:0]  expOut;
        logic [24:0] expAdr;
    } vec_t;

    vec_t vecs[17];

    sdram_port_arb dut (
        .clk             (clk),
        .rst             (rst),
        .c0_req          (c0_req),
        .c1_req          (c1_req),
        .c0_we           (c0_we),
        .c1_we           (c1_we),
        .c0_adr          (c0_adr),
        .c1_adr          (c1_adr),
        .c0_wdata        (c0_wdata),
        .c1_wdata        (c1_wdata),
        .c0_gnt          (c0_gnt),
        .c1_gnt          (c1_gnt),
        .c0_valid        (c0_valid),
        .c1_valid        (c1_valid),
        .c0_done         (c0_done),
        .c1_done         (c1_done),
        .c_rdata         (c_rdata),
        .err             (err),
        .busy            (busy),
        .ready           (ready),
        .wr_req          (wr_req),
        .rd_req          (rd_req),
        .wr_valid        (wr_valid),
        .rd_valid        (rd_valid),
        .adr_sdram       (adr_sdram),
        .data_to_sdram   (data_to_sdram),
        .data_from_sdram (data_from_sdram)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case some sequence wedges.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic logic [9:0] outVec();
        return {c0_gnt, c1_gnt, c0_valid, c1_valid, c0_done, c1_done,
                wr_req, rd_req, err, busy};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        {c0_req, c1_req, c0_we, c1_we, ready, wr_valid, rd_valid} = v.stim;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Serves one burst for the expected client starting from an IDLE negedge.
    task automatic serveBurst(input int expClient, input bit isWrite, input int nWords,
                              input int readyDelay, input int spuriousAt, input bit dropReq);
        int t;
        logic [15:0] word;
        if (readyDelay > 0) ready = 1'b0;
        t = 0;
        while (!(c0_gnt || c1_gnt) && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("gnt_owner", {c1_gnt, c0_gnt}, (expClient == 0) ? 2'b01 : 2'b10);
        checkOutput("adr_latch", adr_sdram, (expClient == 0) ? ADR0 : ADR1);
        if (dropReq) begin
            if (expClient == 0) c0_req = 1'b0;
            else                c1_req = 1'b0;
        end
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clk);
            checkOutput("stall_quiet", {wr_req, rd_req, err}, 3'b000);
        end
        ready = 1'b1;
        #1;
        t = 0;
        while (!(wr_req || rd_req) && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("strobe_dir", {wr_req, rd_req}, isWrite ? 2'b10 : 2'b01);
        for (int i = 0; i < nWords; i++) begin
            if (i == spuriousAt) begin
                wr_valid = !isWrite;
                rd_valid = isWrite;
                #1;
                checkOutput("spurious_ignored", {c1_valid, c0_valid}, 2'b00);
                @(negedge clk);
            end
            word = 16'(16'h1000 * (expClient + 1) + 16'h0111 * i + 5);
            data_from_sdram = word;
            if (expClient == 0) c0_wdata = word;
            else                c1_wdata = word;
            wr_valid = isWrite;
            rd_valid = !isWrite;
            #1;
            checkOutput("valid_route", {c1_valid, c0_valid}, (expClient == 0) ? 2'b01 : 2'b10);
            if (isWrite) checkOutput("wdata_mux", data_to_sdram, word);
            else         checkOutput("rdata_copy", c_rdata, word);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        if (nWords == 8) begin
            checkOutput("done_pulse", {c1_done, c0_done, c1_gnt, c0_gnt},
                        (expClient == 0) ? 4'b0100 : 4'b1000);
            @(negedge clk);
            checkOutput("back_idle", {busy, c1_done, c0_done}, 3'b000);
        end
    endtask

    initial begin
        int n;
        int t;
        bit doneSeen;

        rst = 1'b1;
        {c0_req, c1_req, c0_we, c1_we, ready, wr_valid, rd_valid} = '0;
        c0_adr = ADR0;
        c1_adr = ADR1;
        c0_wdata = '0;
        c1_wdata = '0;
        data_from_sdram = '0;

        // Table: c0 write to 0x100 with gaps and one stray rd_valid.
        vecs[0]  = '{7'b1010100, 10'b0000000000, 25'h0};
        vecs[1]  = '{7'b0010100, 10'b1000000001, ADR0};
        vecs[2]  = '{7'b0010100, 10'b1000001001, ADR0};
        vecs[3]  = '{7'b0010110, 10'b1010001001, ADR0};
        vecs[4]  = '{7'b0010100, 10'b1000000001, ADR0};
        vecs[5]  = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[6]  = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[7]  = '{7'b0010100, 10'b1000000001, ADR0};
        vecs[8]  = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[9]  = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[10] = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[11] = '{7'b0010100, 10'b1000000001, ADR0};
        vecs[12] = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[13] = '{7'b0010101, 10'b1000000001, ADR0};
        vecs[14] = '{7'b0010110, 10'b1010000001, ADR0};
        vecs[15] = '{7'b0010100, 10'b0000100001, ADR0};
        vecs[16] = '{7'b0010100, 10'b0000000000, ADR0};

        @(negedge clk);
        checkOutput("reset_outputs", outVec(), 10'b0);
        checkOutput("reset_adr", adr_sdram, 25'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] table: c0 write burst");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_out", i), outVec(), vecs[i].expOut);
            checkOutput($sformatf("vec%0d_adr", i), adr_sdram, vecs[i].expAdr);
            @(negedge clk);
        end
        {c0_req, c1_req, c0_we, c1_we, wr_valid, rd_valid} = '0;

        $display("[TB] c1 read burst with stray wr_valid");
        c1_we = 1'b0;
        c1_req = 1'b1;
        serveBurst(1, 1'b0, 8, 0, 4, 1'b1);

        $display("[TB] c0 write held off by ready for 20 cycles");
        c0_we = 1'b1;
        c0_req = 1'b1;
        serveBurst(0, 1'b1, 8, 20, -1, 1'b1);

        $display("[TB] c1 read stalls after word 5");
        c1_we = 1'b0;
        c1_req = 1'b1;
        serveBurst(1, 1'b0, 5, 0, -1, 1'b1);
        n = 0;
        doneSeen = 1'b0;
        while (!err && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
            if (c0_done || c1_done) doneSeen = 1'b1;
        end
        checkOutput("wdog_cycles", n, 1023);
        checkOutput("wdog_no_done", doneSeen, 1'b0);
        checkOutput("wdog_abort_state", {busy, c1_gnt, rd_req, err}, 4'b0001);
        @(posedge clk);
        #1;
        checkOutput("wdog_err_pulse", err, 1'b0);
        @(negedge clk);
        c0_we = 1'b1;
        c0_req = 1'b1;
        serveBurst(0, 1'b1, 8, 0, -1, 1'b1);

        $display("[TB] both clients held: round robin");
        applyReset();
        c0_we = 1'b0;
        c1_we = 1'b0;
        c0_req = 1'b1;
        c1_req = 1'b1;
        serveBurst(0, 1'b0, 8, 0, -1, 1'b0);
        serveBurst(1, 1'b0, 8, 0, -1, 1'b0);
        serveBurst(0, 1'b0, 8, 0, -1, 1'b0);
        serveBurst(1, 1'b0, 8, 0, -1, 1'b0);
        c0_req = 1'b0;
        c1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("[TB] reset during word 3");
        c0_we = 1'b1;
        c0_req = 1'b1;
        t = 0;
        while (!c0_gnt && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput("rst_pre_gnt", c0_gnt, 1'b1);
        c0_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_strobe", wr_req, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_outputs", outVec(), 10'b0);
        checkOutput("rst_mid_adr", adr_sdram, 25'h0);
        checkOutput("rst_mid_wdata", data_to_sdram, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        c1_we = 1'b0;
        c1_req = 1'b1;
        serveBurst(1, 1'b0, 8, 0, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Two-client arbiter in front of the SDRAM burst controller. It shares the controller's single request/valid port between two requesters, each able to issue 8-word read or write bursts. Clients are, for example, the MEM→SDRAM writer and the SDRAM→MEM reader. It handles round-robin granting, address latching, routing of `wr_valid`/`rd_valid` and data, burst counting and a stall watchdog.

## Interface
- `ADR_W`, 25: SDRAM word address width.
- `DATA_W`, 16: data width.
- `BURST_LEN`, 8: words per burst; must be a power of two, ≤ 256.
- `TIMEOUT`, 1023: maximum cycles without a matching valid inside a burst before abort.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `c0_req`, `c1_req` in 1: burst request, level; held until `cN_gnt`.
- `c0_we`, `c1_we` in 1: 1 = write burst, 0 = read burst; sampled with the request.
- `c0_adr`, `c1_adr` in ADR_W: burst start address; sampled at grant.
- `c0_wdata`, `c1_wdata` in DATA_W: write word; client advances to the next word after each `cN_valid`.
- `c0_gnt`, `c1_gnt` out 1: registered; high from grant until end of burst.
- `c0_valid`, `c1_valid` out 1: one word transferred this cycle.
- `c0_done`, `c1_done` out 1: one-cycle pulse after the last word.
- `c_rdata` out DATA_W: read data; a direct copy of `data_from_sdram`, shared by both clients.
- `err` out 1: one-cycle pulse on watchdog abort.
- `busy` out 1: state ≠ IDLE.
- `ready` in 1: controller idle / burst finished.
- `wr_req`, `rd_req` out 1: controller strobes.
- `wr_valid`, `rd_valid` in 1: controller word strobes.
- `adr_sdram` out ADR_W: burst address to the controller.
- `data_to_sdram` out DATA_W: write data to the controller.
- `data_from_sdram` in DATA_W: read data from the controller.

## Operation
- States:
  - IDLE → GRANT when any `cN_req` is high.
  - GRANT → ISSUE after exactly one cycle.
  - ISSUE → XFER on the first matching valid.
  - XFER → DONE when the word count reaches BURST_LEN.
  - DONE → IDLE after exactly one cycle.
  - ISSUE or XFER → IDLE on watchdog expiry.
- Arbitration in IDLE:
  - Only one client requesting: it wins.
  - Both requesting: the client not granted last wins.
  - `last` pointer resets to 1, so c0 wins the first tie.
  - `last` updates in DONE and on abort.
- GRANT:
  - Latch `sel`, `we` and `adr_sdram` ← `cSEL_adr`.
  - Assert `cSEL_gnt`.
- ISSUE:
  - While `ready` = 1, assert `wr_req` (we = 1) or `rd_req` (we = 0).
  - The strobe stays high until the first matching valid, then clears on the following edge.
- Matching valid:
  - `wr_valid` when we = 1, `rd_valid` when we = 0.
  - The non-matching strobe is ignored at all times.
  - Any valid outside ISSUE/XFER is ignored.
- Valid routing:
  - `cSEL_valid` = matching valid, combinational, qualified by state ∈ {ISSUE, XFER}.
  - Count the matching valids in a log2(BURST_LEN)+1-bit counter.
  - The BURST_LEN-th valid moves the state to DONE.
- Data path:
  - `data_to_sdram` = `cSEL_wdata`, combinational mux.
  - `c_rdata` = `data_from_sdram`.
- DONE: pulse `cSEL_done`, drop `cSEL_gnt`, clear the counter.
- Watchdog:
  - Counter cleared on each matching valid and on entry to ISSUE.
  - Increments in ISSUE and XFER.
  - On reaching TIMEOUT: pulse `err`, drop the strobe and grant, go to IDLE. No `done` pulse.
- Request handling: requests are sampled only in IDLE; a request deasserted mid-burst has no effect.

## Timing
- Reset values: all outputs 0, state IDLE, `adr_sdram` = 0, counters = 0, `last` = 1.
- Latency:
  - Request to grant: 1 cycle (IDLE edge).
  - Grant to strobe: 1 cycle, plus any wait for `ready`.
  - Valid to `cN_valid`: 0 cycles.
  - Last valid to `done`: 1 cycle.
- Back-to-back bursts:
  - The next grant can be issued on the cycle after DONE.
  - Minimum gap between bursts is 2 cycles.
- `rst` mid-burst clears everything asynchronously. The controller must be reset together with this block.

## Structure
- Package `sdram_arb_pkg`: state enum (IDLE, GRANT, ISSUE, XFER, DONE), default BURST_LEN/TIMEOUT, client-index constants.
- Sub-module `sdram_arb_wdog`: loadable stall counter with clear/enable inputs and an expire output.

## Test plan
- `c0_req`=1, we=1, adr=0x100, `ready`=1, 8 `wr_valid` with gaps → `wr_req` rises 2 cycles after the request, `adr_sdram`=0x100, 8 `c0_valid`, `c0_done` one cycle after the 8th.
- `c0_req` and `c1_req` rise together, both held → grants alternate c0, c1, c0; the second c1 burst is never starved.
- c1 read burst with a spurious `wr_valid` mixed in → only the 8 `rd_valid` are counted; `c_rdata` matches `data_from_sdram` on each `c1_valid`.
- `ready`=0 for 20 cycles in ISSUE → strobe held off and no `err` (TIMEOUT > 20); strobe rises when `ready`=1.
- Valids stop after word 5 → `err` pulses after 1023 idle cycles, no `done`, state IDLE, the next request is served.
- `rst` asserted during word 3 → all outputs 0 immediately; the next `c1_req` is granted normally.
